// File: rtl/aemb_ififo.sv
// aemb_ififo: instruction prefetch FIFO and decode register.
//  Buffers up to DEPTH fetched instruction words. Fetching is decoupled from
//  pipeline stalls. Presents the head word as decode fields and merges an IMM
//  prefix into rSIMM. A branch or exception flushes the queue and injects a
//  NOP bubble.
// Ports:
//  gclk, grst        clock (rising edge), asynchronous active-high reset
//  gena              pipeline advance; the decode register loads only when high
//  rBRA, rXCE        branch taken / exception code; either one flushes the queue
//  iwb_stb_o         fetch request; high while the FIFO has room
//  iwb_dat_i         fetched instruction word
//  iwb_ack_i         fetch acknowledge
//  rOPC..rALT        decode fields of the current instruction
//  rSIMM             sign-extended or IMM-merged immediate
//  rVLD              decode register holds a fetched (non-bubble) word
//  rLVL              FIFO occupancy, 0..DEPTH
module aemb_ififo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned AW     = 2,
    parameter int unsigned BYPASS = 1,
    parameter logic [31:0] NOP    = 32'h8800_0000,
    parameter logic [5:0]  IMMOP  = 6'o54
) (
    input  logic          gclk,
    input  logic          grst,
    input  logic          gena,
    input  logic          rBRA,
    input  logic [1:0]    rXCE,
    output logic          iwb_stb_o,
    input  logic [31:0]   iwb_dat_i,
    input  logic          iwb_ack_i,
    output logic [5:0]    rOPC,
    output logic [4:0]    rRD,
    output logic [4:0]    rRA,
    output logic [15:0]   rIMM,
    output logic [4:0]    rRB,
    output logic [10:0]   rALT,
    output logic [31:0]   rSIMM,
    output logic          rVLD,
    output logic [AW:0]   rLVL
);

    localparam int unsigned LW   = AW + 1;
    localparam logic [AW:0] FULL = LW'(DEPTH);

    // Instruction word as seen by decode.
    typedef struct packed {
        logic [5:0]  opc;
        logic [4:0]  rd;
        logic [4:0]  ra;
        logic [15:0] imm;
    } instr_t;

    logic [31:0]   rFifo [DEPTH];
    logic [AW-1:0] rWrPtr;
    logic [AW-1:0] rRdPtr;

    logic          wFlush;
    logic          wPush;
    logic          wPop;
    logic          wByp;
    logic          wWrEn;
    logic          wReal;
    logic          wMerge;
    logic          wHold;
    logic [AW:0]   wLvlNxt;
    instr_t        wWord;

    // Queue control: acks in a flush cycle are discarded.
    always_comb begin
        wFlush  = rBRA | (|rXCE);
        wPush   = iwb_stb_o & iwb_ack_i & ~wFlush;
        wPop    = gena & ~wFlush & (rLVL != '0);
        wByp    = (BYPASS != 0) & gena & (rLVL == '0) & wPush;
        wWrEn   = wPush & ~wByp;
        wLvlNxt = rLVL;
        if (wFlush) begin
            wLvlNxt = '0;
        end else begin
            wLvlNxt = rLVL + LW'(wWrEn) - LW'(wPop);
        end
    end

    // Word offered to decode: FIFO head, bypassed ack, or a NOP bubble.
    always_comb begin
        wWord = instr_t'(NOP);
        wReal = 1'b0;
        if (wPop) begin
            wWord = instr_t'(rFifo[rRdPtr]);
            wReal = 1'b1;
        end else if (wByp) begin
            wWord = instr_t'(iwb_dat_i);
            wReal = 1'b1;
        end
        // A held IMM prefix is only consumed by a real word, never by a bubble.
        wMerge = rVLD & (rOPC == IMMOP) & wReal;
        wHold  = rVLD & (rOPC == IMMOP) & ~wReal & ~wFlush;
    end

    // FIFO storage; no reset needed since occupancy gates every read.
    always_ff @(posedge gclk) begin
        if (wWrEn) begin
            rFifo[rWrPtr] <= iwb_dat_i;
        end
    end

    // Pointers, occupancy and fetch request.
    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            rWrPtr    <= '0;
            rRdPtr    <= '0;
            rLVL      <= '0;
            iwb_stb_o <= 1'b0;
        end else begin
            rLVL      <= wLvlNxt;
            // Registered from next occupancy, so stb never depends on gena combinationally.
            iwb_stb_o <= (wLvlNxt < FULL);
            if (wWrEn) begin
                rWrPtr <= rWrPtr + AW'(1);
            end
            if (wFlush) begin
                rRdPtr <= rWrPtr;
            end else if (wPop) begin
                rRdPtr <= rRdPtr + AW'(1);
            end
        end
    end

    // Decode register.
    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            rOPC  <= '0;
            rRD   <= '0;
            rRA   <= '0;
            rIMM  <= '0;
            rSIMM <= '0;
            rVLD  <= 1'b0;
        end else if (gena && !wHold) begin
            rOPC  <= wWord.opc;
            rRD   <= wWord.rd;
            rRA   <= wWord.ra;
            rIMM  <= wWord.imm;
            rVLD  <= wReal;
            if (wMerge) begin
                rSIMM <= {rIMM, wWord.imm};
            end else begin
                rSIMM <= {{16{wWord.imm[15]}}, wWord.imm};
            end
        end
    end

    // Register-format views of the immediate field.
    assign rRB  = rIMM[15:11];
    assign rALT = rIMM[10:0];

endmodule

// File: tb/tb_aemb_ififo.sv
// tb_aemb_ififo: directed vectors for aemb_ififo plus a scoreboarded random phase.
module tb_aemb_ififo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;
    localparam logic [31:0] NOPW  = 32'h8800_0000;

    logic        gclk;
    logic        grst;
    logic        gena;
    logic        rBRA;
    logic [1:0]  rXCE;
    logic        iwb_stb_o;
    logic [31:0] iwb_dat_i;
    logic        iwb_ack_i;
    logic [5:0]  rOPC;
    logic [4:0]  rRD;
    logic [4:0]  rRA;
    logic [15:0] rIMM;
    logic [4:0]  rRB;
    logic [10:0] rALT;
    logic [31:0] rSIMM;
    logic        rVLD;
    logic [AW:0] rLVL;

    int nVec = 0;
    int nMis = 0;

    aemb_ififo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .gclk(gclk), .grst(grst), .gena(gena), .rBRA(rBRA), .rXCE(rXCE),
        .iwb_stb_o(iwb_stb_o), .iwb_dat_i(iwb_dat_i), .iwb_ack_i(iwb_ack_i),
        .rOPC(rOPC), .rRD(rRD), .rRA(rRA), .rIMM(rIMM), .rRB(rRB), .rALT(rALT),
        .rSIMM(rSIMM), .rVLD(rVLD), .rLVL(rLVL)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nMis++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge gclk);
        #1;
    endtask

    function automatic logic [31:0] word();
        return {rOPC, rRD, rRA, rIMM};
    endfunction

    logic [31:0] q[$];
    logic [31:0] mWord;
    logic        mVld;
    logic        mStb;
    logic        mPush;
    int          mLvl;

    initial begin
        grst = 1'b0; gena = 1'b0; rBRA = 1'b0; rXCE = 2'b00;
        iwb_dat_i = '0; iwb_ack_i = 1'b0;

        // 1 reset: asynchronous assert mid-clock, pending ack ignored
        repeat (2) @(posedge gclk);
        #3 grst = 1'b1;
        #1;
        chk("rst_word", word(), 32'h0);
        chk("rst_simm", rSIMM, 32'h0);
        chk("rst_vld", 32'(rVLD), 32'h0);
        chk("rst_lvl", 32'(rLVL), 32'h0);
        chk("rst_stb", 32'(iwb_stb_o), 32'h0);
        iwb_ack_i = 1'b1; iwb_dat_i = 32'hDEAD_BEEF;
        tick();
        chk("rst_hold_lvl", 32'(rLVL), 32'h0);
        chk("rst_hold_stb", 32'(iwb_stb_o), 32'h0);
        grst = 1'b0;
        tick();
        chk("rel_stb", 32'(iwb_stb_o), 32'h1);
        chk("rel_lvl", 32'(rLVL), 32'h0);

        // 2 fill with gena low, then drain in order
        for (int i = 1; i <= 4; i++) begin
            iwb_dat_i = 32'h1000_0000 + 32'(i);
            tick();
            chk("fill_lvl", 32'(rLVL), 32'(i));
            chk("fill_stb", 32'(iwb_stb_o), (i < 4) ? 32'h1 : 32'h0);
        end
        iwb_dat_i = 32'hDEAD_0000;
        tick();
        chk("full_lvl", 32'(rLVL), 32'h4);
        chk("full_vld", 32'(rVLD), 32'h0);
        iwb_ack_i = 1'b0; gena = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("drain_word", word(), 32'h1000_0000 + 32'(k));
            chk("drain_vld", 32'(rVLD), 32'h1);
            chk("drain_lvl", 32'(rLVL), 32'(4 - k));
            chk("drain_stb", 32'(iwb_stb_o), 32'h1);
        end
        tick();
        chk("empty_word", word(), NOPW);
        chk("empty_vld", 32'(rVLD), 32'h0);

        // 3 bypass into empty FIFO
        iwb_ack_i = 1'b1; iwb_dat_i = 32'h3021_FFFF;
        tick();
        chk("byp_opc", 32'(rOPC), 32'h0C);
        chk("byp_simm", rSIMM, 32'hFFFF_FFFF);
        chk("byp_lvl", 32'(rLVL), 32'h0);
        chk("byp_vld", 32'(rVLD), 32'h1);
        chk("byp_rb", 32'(rRB), 32'h1F);
        chk("byp_alt", 32'(rALT), 32'h7FF);

        // 4 IMM merge, back to back and across a fetch gap
        iwb_dat_i = 32'hB000_1234;
        tick();
        chk("imm_opc", 32'(rOPC), 32'h2C);
        chk("imm_simm", rSIMM, 32'h0000_1234);
        iwb_dat_i = 32'h3021_5678;
        tick();
        chk("merge_simm", rSIMM, 32'h1234_5678);
        chk("merge_opc", 32'(rOPC), 32'h0C);
        iwb_dat_i = 32'hB000_1234;
        tick();
        iwb_ack_i = 1'b0;
        for (int g = 0; g < 2; g++) begin
            tick();
            chk("gap_opc", 32'(rOPC), 32'h2C);
            chk("gap_vld", 32'(rVLD), 32'h1);
        end
        iwb_ack_i = 1'b1; iwb_dat_i = 32'h3021_5678;
        tick();
        chk("gap_merge_simm", rSIMM, 32'h1234_5678);
        iwb_ack_i = 1'b0;
        tick();
        chk("post_bubble_word", word(), NOPW);
        chk("post_bubble_vld", 32'(rVLD), 32'h0);

        // 5 flush with three queued words and an ack in the same cycle
        gena = 1'b0; iwb_ack_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            iwb_dat_i = 32'h2000_0000 + 32'(i);
            tick();
        end
        chk("pre_flush_lvl", 32'(rLVL), 32'h3);
        gena = 1'b1; rBRA = 1'b1; iwb_dat_i = 32'h2000_0004;
        tick();
        chk("flush_word", word(), NOPW);
        chk("flush_vld", 32'(rVLD), 32'h0);
        chk("flush_lvl", 32'(rLVL), 32'h0);
        chk("flush_simm", rSIMM, 32'h0);
        rBRA = 1'b0; iwb_ack_i = 1'b0;
        tick();
        chk("flush_drop_vld", 32'(rVLD), 32'h0);
        chk("flush_drop_lvl", 32'(rLVL), 32'h0);
        chk("flush_stb", 32'(iwb_stb_o), 32'h1);
        // exception code flushes too
        gena = 1'b0; iwb_ack_i = 1'b1; iwb_dat_i = 32'h2000_0005;
        tick();
        chk("xce_pre_lvl", 32'(rLVL), 32'h1);
        iwb_ack_i = 1'b0; rXCE = 2'b10; gena = 1'b1;
        tick();
        chk("xce_lvl", 32'(rLVL), 32'h0);
        chk("xce_vld", 32'(rVLD), 32'h0);
        rXCE = 2'b00;
        tick();
        chk("xce_after_vld", 32'(rVLD), 32'h0);
        // a flush discards a held IMM prefix
        iwb_ack_i = 1'b1; iwb_dat_i = 32'hB000_1234;
        tick();
        chk("imm_flush_pre", 32'(rOPC), 32'h2C);
        iwb_ack_i = 1'b0; rBRA = 1'b1;
        tick();
        chk("imm_flush_word", word(), NOPW);
        chk("imm_flush_vld", 32'(rVLD), 32'h0);
        rBRA = 1'b0;

        // 6 random gena/ack against a queue model
        mLvl = 0; mWord = NOPW; mVld = 1'b0;
        for (int c = 0; c < 200; c++) begin
            gena      = 1'($urandom_range(0, 1));
            iwb_ack_i = 1'($urandom_range(0, 1));
            iwb_dat_i = 32'h1000_0000 | 32'(c);
            mStb  = (mLvl < DEPTH);
            mPush = mStb & iwb_ack_i;
            if (gena) begin
                if (q.size() != 0) begin
                    mWord = q.pop_front();
                    mVld  = 1'b1;
                    if (mPush) q.push_back(iwb_dat_i);
                end else if (mPush) begin
                    mWord = iwb_dat_i;
                    mVld  = 1'b1;
                end else begin
                    mWord = NOPW;
                    mVld  = 1'b0;
                end
            end else if (mPush) begin
                q.push_back(iwb_dat_i);
            end
            mLvl = q.size();
            tick();
            chk("rnd_lvl", 32'(rLVL), 32'(mLvl));
            chk("rnd_lvl_bound", 32'(rLVL <= 3'(DEPTH)), 32'h1);
            chk("rnd_stb", 32'(iwb_stb_o), 32'(mLvl < DEPTH));
            chk("rnd_word", word(), mWord);
            chk("rnd_vld", 32'(rVLD), 32'(mVld));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
